// File: rtl/mem_output_logic_pkg.sv
// Shared memory-interface encodings, load-source and FSM types used by the
// load path (and the store path, which reuses the op/size encodings).
package mem_output_logic_pkg;

  localparam logic [1:0] MEM_DISABLE   = 2'b00;
  localparam logic [1:0] MEM_READ_SEXT = 2'b01;
  localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
  localparam logic [1:0] MEM_WRITE     = 2'b11;

  localparam logic [1:0] BYTE     = 2'b00;
  localparam logic [1:0] HALFWORD = 2'b01;
  localparam logic [1:0] WORD     = 2'b10;

  localparam logic [31:0] LOAD_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_BUF, SRC_DIN} src_e;
  typedef enum logic [1:0] {ST_IDLE, ST_BRAM_RD, ST_DIN_WAIT} state_e;

  typedef struct packed {
    logic       sext;
    logic [1:0] size;
    logic [1:0] off;
    src_e       src;
  } req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == HALFWORD && off[0]) || (size == WORD && off != 2'b00) || (size == 2'b11);
  endfunction

endpackage

// File: rtl/mem_output_logic_load_align.sv
// Picks the addressed byte lanes out of a raw memory word and extends them;
// faulting accesses return zero with fault raised.
module load_align
  import mem_output_logic_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [1:0]  mem_size,
  input  logic [1:0]  addr_lo,
  input  logic        sext,
  output logic [31:0] load_data,
  output logic        fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // Byte at offset k lives in raw[31-8k -: 8].
    case (addr_lo)
      2'd0:    byte_sel = raw_word[31:24];
      2'd1:    byte_sel = raw_word[23:16];
      2'd2:    byte_sel = raw_word[15:8];
      default: byte_sel = raw_word[7:0];
    endcase
    half_sel = addr_lo[1] ? {raw_word[7:0], raw_word[15:8]}
                          : {raw_word[23:16], raw_word[31:24]};
    fault     = is_misaligned(mem_size, addr_lo);
    load_data = '0;
    if (!fault) begin
      case (mem_size)
        BYTE:     load_data = {{24{sext & byte_sel[7]}}, byte_sel};
        HALFWORD: load_data = {{16{sext & half_sel[15]}}, half_sel};
        default:  load_data = {raw_word[7:0], raw_word[15:8], raw_word[23:16], raw_word[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/mem_output_logic.sv
// Load return path: accepts loads, waits on BRAM latency or the DIN handshake,
// and emits one aligned/extended result pulse per load.
//
//   state       | meaning
//   ST_IDLE     | no load in flight waiting on a source
//   ST_BRAM_RD  | RAM/BUF load issued last cycle, data arriving now
//   ST_DIN_WAIT | DIN load pending; stalling until dinValid
module mem_output_logic
  import mem_output_logic_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memOp,
  input  logic [1:0]  memSize,
  input  logic [31:0] addr,
  input  logic        enRam,
  input  logic        enBuf,
  input  logic        enDin,
  input  logic [31:0] ramDout,
  input  logic [31:0] bufDout,
  input  logic [31:0] dinData,
  input  logic        dinValid,
  output logic        dinReady,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        misalign,
  output logic        stall
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic        pipe_v_q, pipe_v_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        misalign_q, misalign_d;

  logic        accept;
  src_e        req_src;
  logic [31:0] raw_word;
  logic [31:0] aligned;
  logic        align_fault;
  logic        out_fire;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^addr[31:2];

  always_comb begin
    accept = (memOp == MEM_READ_SEXT || memOp == MEM_READ_ZEXT) && !stall;
    if (enRam)      req_src = SRC_RAM;
    else if (enBuf) req_src = SRC_BUF;
    else if (enDin) req_src = SRC_DIN;
    else            req_src = SRC_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DIN_WAIT: if (dinValid) state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        if (accept && (req_src == SRC_RAM || req_src == SRC_BUF)) state_d = ST_BRAM_RD;
        else if (accept && req_src == SRC_DIN)                      state_d = ST_DIN_WAIT;
      end
    endcase
  end

  always_comb begin
    stall    = (state_q == ST_DIN_WAIT);
    dinReady = (state_q == ST_DIN_WAIT);
  end

  // req_q is held through DIN_WAIT because stall blocks new acceptances.
  always_comb begin
    req_d    = req_q;
    pipe_v_d = 1'b0;
    if (accept) begin
      req_d.sext = (memOp == MEM_READ_SEXT);
      req_d.size = memSize;
      req_d.off  = addr[1:0];
      req_d.src  = req_src;
      pipe_v_d   = (req_src != SRC_DIN);
    end

    case (req_q.src)
      SRC_RAM: raw_word = ramDout;
      SRC_BUF: raw_word = bufDout;
      SRC_DIN: raw_word = dinData;
      default: raw_word = LOAD_DEFAULT;
    endcase

    out_fire     = pipe_v_q || (state_q == ST_DIN_WAIT && dinValid);
    load_valid_d = out_fire;
    misalign_d   = out_fire && (req_q.src != SRC_NONE) && align_fault;
    load_data_d  = load_data_q;
    if (out_fire) load_data_d = (req_q.src == SRC_NONE) ? LOAD_DEFAULT : aligned;
  end

  load_align u_load_align (
    .raw_word  (raw_word),
    .mem_size  (req_q.size),
    .addr_lo   (req_q.off),
    .sext      (req_q.sext),
    .load_data (aligned),
    .fault     (align_fault)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q        <= '{sext: 1'b0, size: 2'b00, off: 2'b00, src: SRC_NONE};
      pipe_v_q     <= 1'b0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      load_data_q  <= LOAD_DEFAULT;
    end else begin
      req_q        <= req_d;
      pipe_v_q     <= pipe_v_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
      load_data_q  <= load_data_d;
    end
  end

  assign loadData  = load_data_q;
  assign loadValid = load_valid_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_mem_output_logic.sv
// Bench for mem_output_logic: directed vector table, hand sequences for the
// pipelined, DIN and reset cases, then random traffic against a byte-level model.
module tb_mem_output_logic;
  import mem_output_logic_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  memOp, memSize;
  logic [31:0] addr;
  logic        enRam, enBuf, enDin;
  logic [31:0] ramDout, bufDout, dinData;
  logic        dinValid;
  logic        dinReady, loadValid, misalign, stall;
  logic [31:0] loadData;

  int n_vec  = 0;
  int n_miss = 0;

  mem_output_logic dut (
    .clk(clk), .reset(reset), .memOp(memOp), .memSize(memSize), .addr(addr),
    .enRam(enRam), .enBuf(enBuf), .enDin(enDin), .ramDout(ramDout), .bufDout(bufDout),
    .dinData(dinData), .dinValid(dinValid), .dinReady(dinReady), .loadData(loadData),
    .loadValid(loadValid), .misalign(misalign), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [1:0]  size;
    logic [31:0] a;
    logic [2:0]  en;   // {ram, buf, din}
    logic [31:0] ram;
    logic [31:0] bufd;
    logic        ev;
    logic [31:0] ed;
    logic        em;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_req();
    memOp = MEM_DISABLE; memSize = BYTE; addr = '0;
    enRam = 1'b0; enBuf = 1'b0; enDin = 1'b0;
  endtask

  function automatic void add(input string n, input logic [1:0] op, input logic [1:0] sz,
                              input logic [31:0] a, input logic [2:0] en, input logic [31:0] r,
                              input logic [31:0] b, input logic ev, input logic [31:0] ed,
                              input logic em);
    vec_t v;
    v.name = n; v.op = op; v.size = sz; v.a = a; v.en = en; v.ram = r; v.bufd = b;
    v.ev = ev; v.ed = ed; v.em = em;
    vecs.push_back(v);
  endfunction

  // Reference: split raw word into stored bytes, rebuild the little-endian value.
  function automatic logic [32:0] model(input logic sext, input logic [1:0] size,
                                        input logic [1:0] off, input logic none,
                                        input logic [31:0] raw);
    logic [7:0]  b [4];
    int unsigned v;
    int          nbits;
    int          o;
    if (none) return {1'b0, 32'hDEADBEEF};
    if ((size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0) || size == 2'd3)
      return {1'b1, 32'h0};
    for (int k = 0; k < 4; k++) b[k] = 8'(raw >> (24 - 8 * k));
    o = int'(off);
    if (size == 2'd0) begin
      v = b[o]; nbits = 8;
    end else if (size == 2'd1) begin
      v = b[o] + 256 * b[o + 1]; nbits = 16;
    end else begin
      v = b[0] + 256 * b[1] + 65536 * b[2] + 16777216 * b[3]; nbits = 32;
    end
    if (sext && nbits < 32 && ((v >> (nbits - 1)) & 1) == 1)
      v = v | (32'hFFFF_FFFF << nbits);
    return {1'b0, v[31:0]};
  endfunction

  logic        p_v, p_sext, p_none;
  logic [1:0]  p_size, p_off;
  int          p_src;
  logic        e_v;
  logic [32:0] e_val;
  logic [31:0] last_data;
  int          r;

  initial begin
    reset = 1'b1; idle_req();
    ramDout = '0; bufDout = '0; dinData = '0; dinValid = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_loadValid", 32'(loadValid), 32'd0);
    chk("rst_misalign",  32'(misalign),  32'd0);
    chk("rst_stall",     32'(stall),     32'd0);
    chk("rst_dinReady",  32'(dinReady),  32'd0);
    chk("rst_loadData",  loadData,       32'hDEADBEEF);

    add("lw_sext_100",   MEM_READ_SEXT, WORD,     32'h100,       3'b100, 32'h78563412, 32'h0, 1, 32'h12345678, 0);
    add("lb_sext_103",   MEM_READ_SEXT, BYTE,     32'h103,       3'b100, 32'h000000F0, 32'h0, 1, 32'hFFFFFFF0, 0);
    add("lb_zext_103",   MEM_READ_ZEXT, BYTE,     32'h103,       3'b100, 32'h000000F0, 32'h0, 1, 32'h000000F0, 0);
    add("lh_zext_buf",   MEM_READ_ZEXT, HALFWORD, 32'h1000002,   3'b010, 32'h0,  32'h0000FF80, 1, 32'h000080FF, 0);
    add("lw_mis_102",    MEM_READ_SEXT, WORD,     32'h102,       3'b100, 32'h11223344, 32'h0, 1, 32'h0, 1);
    add("lh_sext_000",   MEM_READ_SEXT, HALFWORD, 32'h000,       3'b100, 32'h80FF0000, 32'h0, 1, 32'hFFFFFF80, 0);
    add("lh_mis_001",    MEM_READ_ZEXT, HALFWORD, 32'h001,       3'b100, 32'h12345678, 32'h0, 1, 32'h0, 1);
    add("size3_fault",   MEM_READ_SEXT, 2'b11,    32'h000,       3'b100, 32'h12345678, 32'h0, 1, 32'h0, 1);
    add("no_source",     MEM_READ_SEXT, WORD,     32'h000,       3'b000, 32'h12345678, 32'h0, 1, 32'hDEADBEEF, 0);
    add("ram_over_buf",  MEM_READ_SEXT, BYTE,     32'h001,       3'b110, 32'h00110000, 32'h00220000, 1, 32'h00000011, 0);
    add("lw_zext_buf",   MEM_READ_ZEXT, WORD,     32'h200,       3'b010, 32'h0,  32'hEFBEADDE, 1, 32'hDEADBEEF, 0);
    add("lb_zext_off2",  MEM_READ_ZEXT, BYTE,     32'h002,       3'b010, 32'h0,  32'h00008000, 1, 32'h00000080, 0);
    add("store_ignored", MEM_WRITE,     WORD,     32'h000,       3'b100, 32'hCAFEF00D, 32'h0, 0, 32'h00000080, 0);
    add("disable_ign",   MEM_DISABLE,   WORD,     32'h000,       3'b100, 32'hCAFEF00D, 32'h0, 0, 32'h00000080, 0);

    foreach (vecs[i]) begin
      memOp = vecs[i].op; memSize = vecs[i].size; addr = vecs[i].a;
      {enRam, enBuf, enDin} = vecs[i].en;
      ramDout = 32'h5555AAAA; bufDout = 32'hAAAA5555;
      step();
      idle_req();
      ramDout = vecs[i].ram; bufDout = vecs[i].bufd;
      chk({vecs[i].name, "_early"}, 32'(loadValid), 32'd0);
      step();
      ramDout = 32'h5555AAAA; bufDout = 32'hAAAA5555;
      chk({vecs[i].name, "_valid"}, 32'(loadValid), 32'(vecs[i].ev));
      chk({vecs[i].name, "_mis"},   32'(misalign),  32'(vecs[i].em));
      chk({vecs[i].name, "_data"},  loadData,       vecs[i].ed);
      step();
      chk({vecs[i].name, "_pulse"}, 32'(loadValid), 32'd0);
    end

    // Back-to-back RAM loads.
    memOp = MEM_READ_SEXT; memSize = WORD; addr = 32'h0; enRam = 1'b1;
    step();
    memOp = MEM_READ_ZEXT; memSize = BYTE; addr = 32'h1; ramDout = 32'h44332211;
    step();
    idle_req(); ramDout = 32'hAABBCCDD;
    chk("b2b_v0", 32'(loadValid), 32'd1);
    chk("b2b_d0", loadData, 32'h11223344);
    step();
    chk("b2b_v1", 32'(loadValid), 32'd1);
    chk("b2b_d1", loadData, 32'h000000BB);
    step();
    chk("b2b_end", 32'(loadValid), 32'd0);

    // DIN load; requester keeps presenting a RAM load while stalled.
    memOp = MEM_READ_SEXT; memSize = WORD; addr = 32'h0; enDin = 1'b1;
    chk("din_pre_stall", 32'(stall), 32'd0);
    step();
    enDin = 1'b0; enRam = 1'b1; ramDout = 32'h01010101;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin dinValid = 1'b1; dinData = 32'h04030201; end
      chk("din_stall",    32'(stall),     32'd1);
      chk("din_ready",    32'(dinReady),  32'd1);
      chk("din_novalid",  32'(loadValid), 32'd0);
      step();
    end
    dinValid = 1'b0; idle_req();
    chk("din_stall_off", 32'(stall),     32'd0);
    chk("din_valid",     32'(loadValid), 32'd1);
    chk("din_data",      loadData,       32'h01020304);
    chk("din_mis",       32'(misalign),  32'd0);
    step();
    chk("din_held_ign",  32'(loadValid), 32'd0);
    step();

    // Reset while in DIN_WAIT, with dinValid in the reset cycle.
    memOp = MEM_READ_SEXT; memSize = WORD; enDin = 1'b1;
    step();
    idle_req();
    chk("rdin_stall", 32'(stall), 32'd1);
    reset = 1'b1; dinValid = 1'b1; dinData = 32'h99999999;
    step();
    reset = 1'b0; dinValid = 1'b0;
    chk("rdin_stall0", 32'(stall),     32'd0);
    chk("rdin_nov0",   32'(loadValid), 32'd0);
    chk("rdin_data",   loadData,       32'hDEADBEEF);
    step();
    chk("rdin_nov1",   32'(loadValid), 32'd0);

    // Reset while a RAM load is in flight.
    memOp = MEM_READ_SEXT; memSize = WORD; enRam = 1'b1;
    step();
    idle_req(); ramDout = 32'h12121212; reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("rram_nov", 32'(loadValid), 32'd0);
    chk("rram_data", loadData, 32'hDEADBEEF);

    // Random traffic (RAM/BUF/NONE sources, DIN only as a lower-priority enable).
    reset = 1'b1; step(); reset = 1'b0;
    p_v = 0; e_v = 0; e_val = '0; last_data = 32'hDEADBEEF;
    p_sext = 0; p_size = 0; p_off = 0; p_none = 0; p_src = 0;
    for (int i = 0; i < 400; i++) begin
      chk("rnd_valid", 32'(loadValid), 32'(e_v));
      if (e_v) last_data = e_val[31:0];
      chk("rnd_mis",  32'(misalign), e_v ? 32'(e_val[32]) : 32'd0);
      chk("rnd_data", loadData, last_data);

      ramDout = $urandom; bufDout = $urandom;
      e_v = p_v;
      if (p_v) e_val = model(p_sext, p_size, p_off, p_none, (p_src == 1) ? ramDout : bufDout);

      memOp = 2'($urandom_range(0, 3));
      memSize = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      r = $urandom_range(0, 3);
      enRam = r[0]; enBuf = r[1];
      enDin = (enRam | enBuf) ? 1'($urandom_range(0, 1)) : 1'b0;
      p_v = (memOp == MEM_READ_SEXT || memOp == MEM_READ_ZEXT);
      p_sext = (memOp == MEM_READ_SEXT);
      p_size = memSize; p_off = addr[1:0];
      p_src = enRam ? 1 : (enBuf ? 2 : 0);
      p_none = (p_src == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_output_logic.md
MEM_OUTPUT_LOGIC -- requirements
Module: mem_output_logic

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- MEM_DISABLE, 2'b00, no access
- MEM_READ_SEXT, 2'b01, sign-extending load
- MEM_READ_ZEXT, 2'b10, zero-extending load
- MEM_WRITE, 2'b11, store
- BYTE, 2'b00, 8-bit access
- HALFWORD, 2'b01, 16-bit access
- WORD, 2'b10, 32-bit access
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  sole clock
- reset  in  1  synchronous active-high reset
- memOp  in  2  request op
- memSize  in  2  request size
- addr  in  32  request byte address
- enRam  in  1  request hits CPU BRAM
- enBuf  in  1  request hits buffer BRAM
- enDin  in  1  request hits DIN register
- ramDout  in  32  CPU BRAM read data, valid the cycle after its request
- bufDout  in  32  buffer BRAM read data, valid the cycle after its request
- dinData  in  32  external input word
- dinValid  in  1  dinData valid
- dinReady  out  1  block accepts dinData
- loadData  out  32  aligned, extended load result
- loadValid  out  1  one-cycle pulse qualifying loadData
- misalign  out  1  one-cycle pulse with loadValid marking a faulting load
- stall  out  1  requester must hold its request

Function
REQ-003 A load is accepted when memOp is MEM_READ_SEXT or MEM_READ_ZEXT and stall is low; MEM_WRITE and MEM_DISABLE are never accepted and produce no output.
REQ-004 On acceptance the block registers sext, memSize, addr[1:0], and the source (RAM, BUF, DIN, NONE; priority RAM>BUF>DIN).
REQ-005 States: IDLE, BRAM_RD, DIN_WAIT.
- IDLE -> BRAM_RD on an accepted RAM/BUF load.
- IDLE -> DIN_WAIT on an accepted DIN load.
- BRAM_RD -> BRAM_RD on another accepted RAM/BUF load; otherwise it follows the IDLE rules.
- DIN_WAIT -> IDLE on dinValid.
REQ-006 RAM/BUF latency: request in cycle N, source data sampled in N+1, loadValid high in N+2; back-to-back loads sustain one result per cycle.
REQ-007 stall and dinReady are high exactly while in DIN_WAIT; requests presented then are ignored and held by the requester.
REQ-008 In DIN_WAIT, dinData is captured in the cycle dinValid is high; loadValid follows in the next cycle.
REQ-009 Byte lanes: stored byte at offset k occupies raw[31-8k -: 8].
- WORD = {raw[7:0], raw[15:8], raw[23:16], raw[31:24]}.
- HALFWORD with addr[1]=0 = {raw[23:16], raw[31:24]}.
- HALFWORD with addr[1]=1 = {raw[7:0], raw[15:8]}.
- DIN data is WORD-formatted identically.
REQ-010 Byte/halfword results are sign-extended from the top bit for SEXT and zero-extended for ZEXT; for WORD the op is ignored.
REQ-011 Faults raise misalign with loadValid, and loadData = 32'h0000_0000. Faults are:
- HALFWORD with addr[0]=1
- WORD with addr[1:0]!=0
- memSize=2'b11
REQ-012 Source NONE (no enable): loadValid in N+2 with loadData = 32'hDEADBEEF and misalign low.
REQ-013 loadData holds its last value between pulses.

Reset
REQ-014 With reset high at a clk edge:
- state -> IDLE
- loadValid, misalign, stall, dinReady -> 0
- loadData -> 32'hDEADBEEF
- all in-flight pipeline entries discarded
REQ-015 Reset during BRAM_RD or DIN_WAIT produces no loadValid for that load; dinValid in the reset cycle is ignored.

Structure
REQ-016 The op/size encodings and the 32'hDEADBEEF default belong in a shared memory-interface package used by both load and store paths.
REQ-017 Alignment/extension is one combinational sub-module, load_align, instantiated once and fed by the selected raw word; the FSM and pipeline registers stay in mem_output_logic.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- RAM LW SEXT, addr 0x100, ramDout 0x78563412 -> loadData 0x12345678 in N+2, misalign 0.
- RAM LB SEXT, addr 0x103, ramDout 0x000000F0 -> 0xFFFFFFF0; same load with ZEXT -> 0x000000F0.
- BUF LH ZEXT, addr 0x1000002, bufDout 0x0000FF80 -> 0x000080FF.
- Back-to-back RAM loads in cycles N and N+1 -> loadValid in N+2 and N+3 with the correct data each.
- DIN load with dinValid delayed 3 cycles, dinData 0x04030201 -> stall/dinReady high 3 cycles, then loadData 0x01020304.
- LW at addr 0x102 -> misalign=1 and loadData 0; reset asserted in DIN_WAIT -> stall 0 next cycle, no loadValid.
